fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 148 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops words from a show-ahead FIFO and serialises them as UART
//               frames (start, data LSB first, optional even parity, stop).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_read,
    output logic                  read,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BW = $clog2(DATA_WIDTH + 1);

    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DATA_WIDTH - 1);
    localparam logic [c_BW-1:0] c_STOP_LAST = c_BW'(STOP_BITS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [c_CW-1:0]       r_baud;
    logic [c_BW-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_tx;

    logic                  w_bit_end;
    logic                  w_last_stop;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_bit_end    = (r_baud == c_BAUD_LAST);
    assign w_last_stop  = (r_state == c_STOP) && w_bit_end && (r_bit_cnt == c_STOP_LAST);
    // Gating with rst_n keeps the pop strobe low for the whole reset window.
    assign w_pop        = rst_n && enable && !empty &&
                          ((r_state == c_IDLE) || w_last_stop);
    assign w_shift_next = r_shift >> 1;

    assign read       = w_pop;
    assign tx         = r_tx;
    assign busy       = (r_state != c_IDLE);
    assign frame_done = w_last_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            if (r_state != c_IDLE) begin
                r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
            end

            // r_tx is loaded with the level of the upcoming bit at each boundary.
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_state <= c_START;
                        r_shift <= data_read;
                        r_par   <= ^data_read;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_state   <= c_DATA;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == c_DATA_LAST) begin
                            r_bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_state <= c_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= c_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx      <= w_shift_next[0];
                        end
                    end
                end
                c_PARITY: begin
                    if (w_bit_end) begin
                        r_state   <= c_STOP;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                    end
                end
                c_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == c_STOP_LAST) begin
                            r_bit_cnt <= '0;
                            if (w_pop) begin
                                r_state <= c_START;
                                r_shift <= data_read;
                                r_par   <= ^data_read;
                                r_tx    <= 1'b0;
                            end else begin
                                r_state <= c_IDLE;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx against a bit-level
//               frame model; two instances cover 8N1 and 8E2 framing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int LEN0 = (1 + 8 + 0 + 1) * CPB;
    localparam int LEN1 = (1 + 8 + 1 + 2) * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable0 = 1'b0, enable1 = 1'b0;
    logic       empty0, empty1;
    logic [7:0] data0, data1;
    logic       read0, tx0, busy0, fd0;
    logic       read1, tx1, busy1, fd1;

    int n_tests = 0;
    int n_fail  = 0;

    // Show-ahead FIFO models: tests only append, the pop process only advances rd_ptr.
    logic [7:0] words0 [64];
    logic [7:0] words1 [64];
    int n_push0 = 0, n_push1 = 0;
    int rd_ptr0 = 0, rd_ptr1 = 0;

    assign empty0 = (rd_ptr0 >= n_push0);
    assign empty1 = (rd_ptr1 >= n_push1);
    assign data0  = words0[rd_ptr0[5:0]];
    assign data1  = words1[rd_ptr1[5:0]];

    always @(posedge clk) begin
        if (read0) rd_ptr0 <= rd_ptr0 + 1;
        if (read1) rd_ptr1 <= rd_ptr1 + 1;
    end

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable0), .empty(empty0), .data_read(data0),
        .read(read0), .tx(tx0), .busy(busy0), .frame_done(fd0)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable1), .empty(empty1), .data_read(data1),
        .read(read1), .tx(tx1), .busy(busy1), .frame_done(fd1)
    );

    // Line level 'cyc' cycles after the pop cycle: start, data LSB first, parity, stop(s).
    function automatic logic model_tx(input logic [7:0] w, input int par_en, input int cyc);
        int b;
        b = cyc / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return w[b-1];
        if (par_en != 0 && b == 9) return ^w;
        return 1'b1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] w);
        words0[n_push0[5:0]] = w;
        n_push0++;
    endtask

    task automatic push1(input logic [7:0] w);
        words1[n_push1[5:0]] = w;
        n_push1++;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        n_tests++;
        if ({tx0, busy0, fd0, read0, tx1, busy1, fd1, read1} !== 8'b1000_1000) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp %b",
                     {tx0, busy0, fd0, read0, tx1, busy1, fd1, read1}, 8'b1000_1000);
        end
        enable0 = 1'b1;
        push0(8'hA5);
        #1;
        n_tests++;
        if (read0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read_blocked got %b exp 0", read0);
        end
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        logic [7:0] w;
        int t;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                push0(8'($urandom));
                #1;
            end
            w = words0[rd_ptr0[5:0]];
            t = 0;
            while (!read0 && t < 20) begin
                tick();
                t++;
            end
            n_tests++;
            if (t != 0) begin
                n_fail++;
                $display("FAIL single_pop_latency word=%0d got %0d cycles exp 0", k, t);
                return;
            end
            for (int c = 1; c <= LEN0; c++) begin
                tick();
                n_tests++;
                if ({tx0, busy0, fd0, read0} !== {model_tx(w, 0, c - 1), 1'b1, (c == LEN0), 1'b0}) begin
                    n_fail++;
                    $display("FAIL single_frame w=%h c=%0d got tx/busy/fd/read=%b exp %b", w, c,
                             {tx0, busy0, fd0, read0}, {model_tx(w, 0, c - 1), 1'b1, (c == LEN0), 1'b0});
                end
            end
            tick();
            n_tests++;
            if ({tx0, busy0} !== 2'b10) begin
                n_fail++;
                $display("FAIL single_idle_after w=%h got tx/busy=%b exp 10", w, {tx0, busy0});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ws [3];
        int t;
        int f, k;
        ws[0] = 8'h00;
        ws[1] = 8'hFF;
        ws[2] = 8'($urandom);
        for (int i = 0; i < 3; i++) push0(ws[i]);
        #1;
        t = 0;
        while (!read0 && t < 20) begin
            tick();
            t++;
        end
        n_tests++;
        if (!read0) begin
            n_fail++;
            $display("FAIL b2b_first_pop timeout got read=%b exp 1", read0);
            return;
        end
        for (int c = 1; c <= 3 * LEN0; c++) begin
            tick();
            f = (c - 1) / LEN0;
            k = (c - 1) % LEN0;
            n_tests++;
            if ({tx0, busy0, fd0, read0} !==
                {model_tx(ws[f], 0, k), 1'b1, (k == LEN0 - 1), (k == LEN0 - 1 && f < 2)}) begin
                n_fail++;
                $display("FAIL b2b_frame c=%0d got tx/busy/fd/read=%b exp %b", c, {tx0, busy0, fd0, read0},
                         {model_tx(ws[f], 0, k), 1'b1, (k == LEN0 - 1), (k == LEN0 - 1 && f < 2)});
            end
        end
        tick();
        n_tests++;
        if ({tx0, busy0} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_idle_after got tx/busy=%b exp 10", {tx0, busy0});
        end
    endtask

    task automatic test_parity();
        logic [7:0] w;
        int t;
        enable1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = (i == 0) ? 8'h07 : 8'($urandom);
            push1(w);
            #1;
            t = 0;
            while (!read1 && t < 20) begin
                tick();
                t++;
            end
            n_tests++;
            if (!read1) begin
                n_fail++;
                $display("FAIL parity_pop timeout w=%h got read=%b exp 1", w, read1);
                return;
            end
            for (int c = 1; c <= LEN1; c++) begin
                tick();
                n_tests++;
                if ({tx1, busy1, fd1, read1} !== {model_tx(w, 1, c - 1), 1'b1, (c == LEN1), 1'b0}) begin
                    n_fail++;
                    $display("FAIL parity_frame w=%h c=%0d got tx/busy/fd/read=%b exp %b", w, c,
                             {tx1, busy1, fd1, read1}, {model_tx(w, 1, c - 1), 1'b1, (c == LEN1), 1'b0});
                end
            end
            tick();
            n_tests++;
            if ({tx1, busy1} !== 2'b10) begin
                n_fail++;
                $display("FAIL parity_idle_after w=%h got tx/busy=%b exp 10", w, {tx1, busy1});
            end
        end
        enable1 = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [7:0] w;
        int t;
        for (int i = 0; i < 3; i++) push0(8'($urandom));
        w = words0[rd_ptr0[5:0]];
        #1;
        t = 0;
        while (!read0 && t < 20) begin
            tick();
            t++;
        end
        n_tests++;
        if (!read0) begin
            n_fail++;
            $display("FAIL endrop_pop timeout got read=%b exp 1", read0);
            return;
        end
        for (int c = 1; c <= LEN0 + 12; c++) begin
            tick();
            if (c == 10) enable0 = 1'b0;
            n_tests++;
            if ({tx0, busy0, fd0, read0} !==
                {(c <= LEN0) ? model_tx(w, 0, c - 1) : 1'b1, (c <= LEN0), (c == LEN0), 1'b0}) begin
                n_fail++;
                $display("FAIL endrop_frame c=%0d got tx/busy/fd/read=%b exp %b", c, {tx0, busy0, fd0, read0},
                         {(c <= LEN0) ? model_tx(w, 0, c - 1) : 1'b1, (c <= LEN0), (c == LEN0), 1'b0});
            end
        end
        n_tests++;
        if (n_push0 - rd_ptr0 != 2) begin
            n_fail++;
            $display("FAIL endrop_words_left got %0d exp 2", n_push0 - rd_ptr0);
        end
        n_push0 = rd_ptr0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] w0, w1;
        int t;
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        push0(w0);
        push0(w1);
        enable0 = 1'b1;
        #1;
        t = 0;
        while (!read0 && t < 20) begin
            tick();
            t++;
        end
        n_tests++;
        if (!read0) begin
            n_fail++;
            $display("FAIL rstmid_pop timeout got read=%b exp 1", read0);
            return;
        end
        for (int c = 1; c <= 15; c++) begin
            tick();
            n_tests++;
            if ({tx0, busy0} !== {model_tx(w0, 0, c - 1), 1'b1}) begin
                n_fail++;
                $display("FAIL rstmid_pre c=%0d got tx/busy=%b exp %b", c, {tx0, busy0},
                         {model_tx(w0, 0, c - 1), 1'b1});
            end
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({tx0, busy0, fd0, read0} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rstmid_async got tx/busy/fd/read=%b exp 1000", {tx0, busy0, fd0, read0});
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if ({read0, data0} !== {1'b1, w1}) begin
            n_fail++;
            $display("FAIL rstmid_repop got read/data=%b/%h exp 1/%h", read0, data0, w1);
            return;
        end
        for (int c = 1; c <= LEN0 + 1; c++) begin
            tick();
            n_tests++;
            if ({tx0, busy0, fd0} !== {(c <= LEN0) ? model_tx(w1, 0, c - 1) : 1'b1, (c <= LEN0), (c == LEN0)}) begin
                n_fail++;
                $display("FAIL rstmid_frame c=%0d got tx/busy/fd=%b exp %b", c, {tx0, busy0, fd0},
                         {(c <= LEN0) ? model_tx(w1, 0, c - 1) : 1'b1, (c <= LEN0), (c == LEN0)});
            end
        end
    endtask

    task automatic test_idle_empty();
        int bad;
        bad = 0;
        enable0 = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            tick();
            n_tests++;
            if ({read0, tx0, busy0} !== 3'b010) begin
                n_fail++;
                bad++;
                if (bad < 5) $display("FAIL idle_empty c=%0d got read/tx/busy=%b exp 010", c, {read0, tx0, busy0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_enable_drop();
        test_reset_mid();
        test_idle_empty();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
